// File: rtl/comp_seq_ctrl_pkg.sv
// Shared definitions for the sequential nibble-serial magnitude comparator.
package comp_seq_ctrl_pkg;

  localparam int NW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CMP  = 2'b01,
    S_FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/comp_4bit.sv
// Combinational 4-bit magnitude comparator; exactly one output is high.
module comp_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       IG,
  output logic       MA,
  output logic       ME
);

  assign IG = (A == B);
  assign MA = (A > B);
  assign ME = (A < B);

endmodule

// File: rtl/comp_seq_ctrl.sv
// Wide-operand magnitude compare, one nibble per clock, MSB nibble first,
// through a single shared comp_4bit; stops at the first unequal nibble.
module comp_seq_ctrl
  import comp_seq_ctrl_pkg::*;
#(
  parameter int NIB = 4,
  parameter int CW  = $clog2(NIB + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [4*NIB-1:0]  A,
  input  logic [4*NIB-1:0]  B,
  output logic              BUSY,
  output logic              DONE,
  output logic              IG,
  output logic              MA,
  output logic              ME,
  output logic [CW-1:0]     CYC
);

  localparam int W  = NW * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  state_e          state_q, state_d;
  logic [W-1:0]    rega_q, rega_d;
  logic [W-1:0]    regb_q, regb_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            ig_q, ig_d;
  logic            ma_q, ma_d;
  logic            me_q, me_d;

  logic [NW-1:0]   nib_a, nib_b;
  logic            c_ig, c_ma, c_me;

  // Constant-index mux keeps the nibble select width-clean for any NIB.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = rega_q[i*NW +: NW];
        nib_b = regb_q[i*NW +: NW];
      end
    end
  end

  comp_4bit u_cmp (
    .A  (nib_a),
    .B  (nib_b),
    .IG (c_ig),
    .MA (c_ma),
    .ME (c_me)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      rega_q  <= '0;
      regb_q  <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
      ig_q    <= 1'b0;
      ma_q    <= 1'b0;
      me_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      ig_q    <= ig_d;
      ma_q    <= ma_d;
      me_q    <= me_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    ig_d    = ig_q;
    ma_d    = ma_q;
    me_d    = me_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          rega_d  = A;
          regb_d  = B;
          idx_d   = IW'(NIB - 1);
          cyc_d   = '0;
          ig_d    = 1'b0;
          ma_d    = 1'b0;
          me_d    = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        cyc_d = cyc_q + CW'(1);
        if (c_ma) begin
          ma_d    = 1'b1;
          state_d = S_FIN;
        end else if (c_me) begin
          me_d    = 1'b1;
          state_d = S_FIN;
        end else if (c_ig && idx_q == '0) begin
          ig_d    = 1'b1;
          state_d = S_FIN;
        end else if (c_ig) begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY = (state_q == S_CMP) || (state_q == S_FIN);
  assign DONE = (state_q == S_FIN);
  assign IG   = ig_q;
  assign MA   = ma_q;
  assign ME   = me_q;
  assign CYC  = cyc_q;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed plus randomized checks of comp_seq_ctrl (NIB=4 and NIB=1 builds)
// against a whole-operand arithmetic reference model.
module tb_comp_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START0, START1;
  logic [15:0] A0, B0;
  logic [3:0]  A1, B1;
  logic        BUSY0, DONE0, IG0, MA0, ME0;
  logic [2:0]  CYC0;
  logic        BUSY1, DONE1, IG1, MA1, ME1;
  logic [0:0]  CYC1;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  comp_seq_ctrl #(.NIB(4)) dut4 (
    .CLK(CLK), .RST(RST), .START(START0), .A(A0), .B(B0),
    .BUSY(BUSY0), .DONE(DONE0), .IG(IG0), .MA(MA0), .ME(ME0), .CYC(CYC0)
  );

  comp_seq_ctrl #(.NIB(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START1), .A(A1), .B(B1),
    .BUSY(BUSY1), .DONE(DONE1), .IG(IG1), .MA(MA1), .ME(ME1), .CYC(CYC1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: res 0 equal, 1 A>B, 2 A<B; cyc = nibbles examined until first difference.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input int nib,
                                output int res, output int cyc);
    int unsigned va, vb;
    va = 0; vb = 0;
    for (int i = 0; i < nib; i++) begin
      va += ((int'(a) >> (4*i)) & 15) << (4*i);
      vb += ((int'(b) >> (4*i)) & 15) << (4*i);
    end
    res = (va == vb) ? 0 : (va > vb) ? 1 : 2;
    cyc = nib;
    for (int k = 0; k < nib; k++) begin
      if (((va >> (4*(nib-1-k))) & 15) != ((vb >> (4*(nib-1-k))) & 15)) begin
        cyc = k + 1;
        break;
      end
    end
  endfunction

  task automatic get(input int inst, output logic busy, output logic done, output logic ig,
                     output logic ma, output logic me, output int cyc);
    busy = inst == 0 ? BUSY0 : BUSY1;
    done = inst == 0 ? DONE0 : DONE1;
    ig   = inst == 0 ? IG0 : IG1;
    ma   = inst == 0 ? MA0 : MA1;
    me   = inst == 0 ? ME0 : ME1;
    cyc  = inst == 0 ? int'(CYC0) : int'(CYC1);
  endtask

  task automatic launch(input int inst, input logic [15:0] a, input logic [15:0] b, input bit keep);
    @(negedge CLK);
    if (inst == 0) begin A0 = a; B0 = b; START0 = 1'b1; end
    else begin A1 = a[3:0]; B1 = b[3:0]; START1 = 1'b1; end
    @(posedge CLK);
    #1;
    if (!keep) begin START0 = 1'b0; START1 = 1'b0; end
    A0 = 16'($urandom); B0 = 16'($urandom);
    A1 = 4'($urandom);  B1 = 4'($urandom);
  endtask

  // Returns the cycle number (edge 0 = START sample) in which DONE was seen.
  task automatic wait_done(input int inst, output int n);
    logic busy, done, ig, ma, me;
    int   cyc;
    n = 1;
    @(negedge CLK);
    while (n <= 20) begin
      get(inst, busy, done, ig, ma, me, cyc);
      check("busy_during_cmp", {31'd0, busy}, 32'd1);
      if (done) break;
      if (n == 1) check("results_cleared", {29'd0, ig, ma, me}, 32'd0);
      @(negedge CLK);
      n++;
    end
    if (n > 20) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic verify(input int inst, input logic [15:0] a, input logic [15:0] b, input int n);
    logic busy, done, ig, ma, me;
    int   cyc, res, ecyc;
    model(a, b, inst == 0 ? 4 : 1, res, ecyc);
    get(inst, busy, done, ig, ma, me, cyc);
    check("latency", n, ecyc + 1);
    check("cyc", cyc, ecyc);
    check("ig_ma_me", {29'd0, ig, ma, me},
          res == 0 ? 32'd4 : res == 1 ? 32'd2 : 32'd1);
  endtask

  task automatic run(input int inst, input logic [15:0] a, input logic [15:0] b);
    int   n, cyc;
    logic busy, done, ig, ma, me;
    launch(inst, a, b, 1'b0);
    wait_done(inst, n);
    verify(inst, a, b, n);
    @(negedge CLK);
    get(inst, busy, done, ig, ma, me, cyc);
    check("done_one_pulse", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int   n, cyc;
    logic busy, done, ig, ma, me;
    logic [15:0] ra, rb;

    RST = 1'b1; START0 = 1'b0; START1 = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    #12;
    check("reset_outputs", {23'd0, BUSY0, DONE0, IG0, MA0, ME0, CYC0}, 32'd0);
    check("reset_outputs1", {25'd0, BUSY1, DONE1, IG1, MA1, ME1, CYC1}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    run(0, 16'h1234, 16'h1234);

    run(0, 16'h8000, 16'h7FFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("held_idle", {24'd0, DONE0, IG0, MA0, ME0, CYC0}, {24'd0, 1'b0, 3'b010, 3'd1});
    end

    run(0, 16'h12F3, 16'h12F4);
    run(0, 16'h0000, 16'hFFFF);

    // START held high across a run; A changes while busy.
    launch(0, 16'h0050, 16'h0040, 1'b1);
    A0 = 16'h0000; B0 = 16'h0040;
    wait_done(0, n);
    verify(0, 16'h0050, 16'h0040, n);
    @(negedge CLK);
    check("idle_after_fin", {30'd0, BUSY0, MA0}, 32'd1);
    @(posedge CLK);
    #1;
    START0 = 1'b0;
    wait_done(0, n);
    verify(0, 16'h0000, 16'h0040, n);
    @(negedge CLK);

    // Asynchronous reset in cycle 3 of an all-equal compare.
    launch(0, 16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    check("pre_reset_busy_cyc", {28'd0, BUSY0, CYC0}, {28'd0, 1'b1, 3'd2});
    RST = 1'b1;
    #1;
    check("async_reset", {23'd0, BUSY0, DONE0, IG0, MA0, ME0, CYC0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("no_done_in_reset", {31'd0, DONE0}, 32'd0);
    end
    RST = 1'b0;
    run(0, 16'hFFFF, 16'hFFFF);

    run(1, 16'h0009, 16'h0009);
    run(1, 16'h0000, 16'h000F);

    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = ra;
      case ($urandom_range(0, 4))
        0: rb = 16'($urandom);
        1: rb[3:0]   = 4'($urandom);
        2: rb[7:4]   = 4'($urandom);
        3: rb[11:8]  = 4'($urandom);
        default: ;
      endcase
      run(0, ra, rb);
      run(1, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/comp_seq_ctrl.md
Name: comp_seq_ctrl

Overview:
Sequential magnitude-compare controller for wide operands (NIB nibbles) that time-shares a single comp_4bit instance. It compares one nibble per clock, most significant nibble first, and stops at the first unequal nibble. It exposes a START/BUSY/DONE handshake and registered one-hot IG/MA/ME results. It sits between a requesting datapath and the shared 4-bit comparator.

Parameters:
NIB, 4, number of 4-bit nibbles per operand (operand width 4*NIB, NIB >= 1)
CW, $clog2(NIB+1), width of the CYC counter output

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
START  in  1  compare request; sampled only in IDLE
A  in  4*NIB  operand A; captured on the accepted START
B  in  4*NIB  operand B; captured on the accepted START
BUSY  out  1  high while a compare is in progress (states CMP and FIN)
DONE  out  1  one-cycle pulse; results are valid from this cycle on
IG  out  1  A == B (registered, held until the next accepted START)
MA  out  1  A > B (registered, held)
ME  out  1  A < B (registered, held)
CYC  out  CW  number of nibble compares used; valid with DONE, held

Behaviour:
- One clock. RST is asynchronous and active-high.
- Reset values:
  - State IDLE; BUSY, DONE, IG, MA, ME = 0; CYC = 0.
  - Internal operand registers and nibble index are cleared to 0.
- States:
  - IDLE: BUSY=0. On START=1 at a rising edge:
    - capture A and B into regA and regB;
    - idx <= NIB-1; CYC <= 0;
    - clear IG, MA and ME to 0;
    - go to CMP.
  - CMP: BUSY=1. The comparator inputs are regA[4*idx+3:4*idx] and regB[4*idx+3:4*idx]; the comparator is combinational. At each edge CYC <= CYC+1, then:
    - comparator MA=1: MA<=1, go to FIN;
    - comparator ME=1: ME<=1, go to FIN;
    - comparator IG=1 and idx==0: IG<=1, go to FIN;
    - comparator IG=1 and idx>0: idx <= idx-1, stay in CMP.
  - FIN: BUSY=1, DONE=1 for exactly one cycle, then go to IDLE.
- Latency:
  - Let the first unequal nibble be the j-th from the top, with j = 0..NIB-1.
  - Counting the START-sampling edge as edge 0, DONE is high in cycle j+2 and CYC = j+1.
  - All nibbles equal: DONE is high in cycle NIB+1 and CYC = NIB.
  - Best case is 2 cycles; worst case is NIB+1 cycles.
- Handshake and boundary conditions:
  - START in CMP or FIN is ignored. Operand changes on A/B during BUSY have no effect on the result.
  - START held high continuously: a new compare is accepted on the first IDLE cycle after FIN. Back-to-back throughput is one compare per (latency+1) cycles.
  - idx never underflows; the idx==0 equal case terminates unconditionally.
  - Exactly one of IG/MA/ME is 1 after DONE. All three are 0 between START acceptance and DONE, and after reset.
  - RST asserted mid-operation: immediate return to reset values with no DONE pulse. The pending request is lost and must be re-issued.
  - NIB=1: single compare; DONE in cycle 2, CYC=1.

Decomposition:
- A shared package holds:
  - state encoding S_IDLE=2'b00, S_CMP=2'b01, S_FIN=2'b10;
  - nibble width constant NW=4.
- One sub-module: the existing comp_4bit. Instantiate it once, drive it with the selected nibbles, and use its IG/MA/ME as the combinational decision.
- The FSM, index counter, operand registers and result registers live in comp_seq_ctrl.

Test Plan:
1. NIB=4, reset, then START with A=16'h1234, B=16'h1234 -> BUSY for 5 cycles; DONE in cycle 5; IG=1, MA=0, ME=0, CYC=4.
2. A=16'h8000, B=16'h7FFF -> DONE in cycle 2; MA=1, CYC=1. Results are held stable across 10 idle cycles.
3. A=16'h12F3, B=16'h12F4 -> DONE in cycle 5; ME=1, CYC=4. A=16'h0000, B=16'hFFFF -> ME=1, CYC=1.
4. START with A=16'h0050, B=16'h0040. Keep START high and change A to 16'h0000 while BUSY -> MA=1, CYC=3 (first run unaffected). The next compare starts the cycle after FIN and yields ME=1, CYC=3.
5. START with A=B=16'hFFFF, then assert RST in cycle 3 -> BUSY, DONE, IG, MA, ME and CYC go to 0 without waiting for a clock edge, and no DONE pulse appears. After RST is released, a new START completes normally.
6. NIB=1 build: A=4'h9, B=4'h9 -> IG=1, CYC=1, DONE in cycle 2. A=4'h0, B=4'hF -> ME=1.
